// File: rtl/cmd_parser_pkg.sv
// Shared constants for the host command parser: header OP byte layout,
// word-size codes and parser state encodings.
package cmd_parser_pkg;

    localparam logic [3:0] CMD_MAGIC       = 4'hA;

    localparam logic [1:0] CMD_WSIZE_1BYTE = 2'd0;
    localparam logic [1:0] CMD_WSIZE_2BYTE = 2'd1;
    localparam logic [1:0] CMD_WSIZE_4BYTE = 2'd2;

    localparam int         HDR_ADDR_BYTES  = 4;

    localparam logic [2:0] ST_OP   = 3'd0;
    localparam logic [2:0] ST_SIZE = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_RESP = 3'd3;
    localparam logic [2:0] ST_MREQ = 3'd4;

    typedef struct packed {
        logic [3:0] magic;
        logic       aincr;
        logic [1:0] wsize;
        logic       wr;
    } cmd_op_t;

    // An OP byte is accepted only with the right magic and a defined word size.
    function automatic logic op_is_valid(input cmd_op_t op);
        return (op.magic == CMD_MAGIC) &&
               (op.wsize inside {CMD_WSIZE_1BYTE, CMD_WSIZE_2BYTE, CMD_WSIZE_4BYTE});
    endfunction

endpackage

// File: rtl/cmd_parser_timeout.sv
// Idle watchdog for a partially received header: reloads on clear, counts
// down while enabled, and pulses expired once the budget is used up.
module cmd_timeout #(
    parameter int CYCLES = 1000000,
    parameter int W      = $clog2(CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= W'(CYCLES - 1);
        end else if (enable && count != '0) begin
            count <= count - W'(1);
        end
    end

    // A clear in the same cycle (a byte arriving) suppresses expiry.
    assign expired = enable && !clear && (count == '0);

endmodule

// File: rtl/cmd_parser.sv
// Host command parser: turns the host Rx byte stream into an MREQ for the
// Wishbone engine, echoes the OP byte, then bridges the payload streams.
module cmd_parser
    import cmd_parser_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    input  logic [7:0]  i_rx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_mreq_valid,
    input  logic        i_mreq_ready,
    output logic        o_mreq_wr,
    output logic [1:0]  o_mreq_wsize,
    output logic        o_mreq_aincr,
    output logic [7:0]  o_mreq_size,
    output logic [31:0] o_mreq_addr,
    output logic        o_drx_valid,
    input  logic        i_drx_ready,
    output logic [7:0]  o_drx_data,
    input  logic        i_dtx_valid,
    output logic        o_dtx_ready,
    input  logic [7:0]  i_dtx_data,
    output logic        o_busy,
    output logic [7:0]  o_err_count
);

    logic [2:0]  state;
    logic [7:0]  op_byte;
    logic        mreq_wr;
    logic [1:0]  mreq_wsize;
    logic        mreq_aincr;
    logic [7:0]  mreq_size;
    logic [31:0] mreq_addr;
    logic [1:0]  addr_idx;
    logic [7:0]  err_count;

    cmd_op_t     op_in;
    logic        op_ok;
    logic        in_header;
    logic        waiting;
    logic        hdr_ack;
    logic        timeout_hit;
    logic        bump_err;

    assign op_in     = cmd_op_t'(i_rx_data);
    assign op_ok     = op_is_valid(op_in);
    assign in_header = (state == ST_OP) || (state == ST_SIZE) || (state == ST_ADDR);
    assign waiting   = (state == ST_SIZE) || (state == ST_ADDR);
    assign hdr_ack   = i_rx_valid && in_header;
    assign bump_err  = (hdr_ack && state == ST_OP && !op_ok) || timeout_hit;

    cmd_timeout #(
        .CYCLES (TIMEOUT_CYCLES),
        .W      (TIMEOUT_W)
    ) u_timeout (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (hdr_ack || !waiting),
        .enable  (waiting),
        .expired (timeout_hit)
    );

    // Header FSM; a timeout drops back to ST_OP and discards the partial header.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_OP;
            op_byte    <= '0;
            mreq_wr    <= 1'b0;
            mreq_wsize <= '0;
            mreq_aincr <= 1'b0;
            mreq_size  <= '0;
            mreq_addr  <= '0;
            addr_idx   <= '0;
            err_count  <= '0;
        end else begin
            if (bump_err && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
            case (state)
                ST_OP: begin
                    if (hdr_ack && op_ok) begin
                        op_byte    <= i_rx_data;
                        mreq_wr    <= op_in.wr;
                        mreq_wsize <= op_in.wsize;
                        mreq_aincr <= op_in.aincr;
                        state      <= ST_SIZE;
                    end
                end
                ST_SIZE: begin
                    if (hdr_ack) begin
                        mreq_size <= i_rx_data;
                        addr_idx  <= '0;
                        state     <= ST_ADDR;
                    end else if (timeout_hit) begin
                        state <= ST_OP;
                    end
                end
                ST_ADDR: begin
                    if (hdr_ack) begin
                        mreq_addr[{addr_idx, 3'b000} +: 8] <= i_rx_data;
                        addr_idx <= addr_idx + 2'd1;
                        if (addr_idx == 2'(HDR_ADDR_BYTES - 1)) begin
                            state <= ST_RESP;
                        end
                    end else if (timeout_hit) begin
                        state <= ST_OP;
                    end
                end
                ST_RESP: begin
                    if (i_tx_ready) begin
                        state <= ST_MREQ;
                    end
                end
                ST_MREQ: begin
                    if (i_mreq_ready) begin
                        state <= ST_OP;
                    end
                end
                default: state <= ST_OP;
            endcase
        end
    end

    // Stream routing: header bytes, the echo, then zero-latency payload bridging.
    always_comb begin
        o_rx_ready  = 1'b0;
        o_tx_valid  = 1'b0;
        o_tx_data   = 8'h00;
        o_drx_valid = 1'b0;
        o_drx_data  = 8'h00;
        o_dtx_ready = 1'b0;
        if (in_header) begin
            o_rx_ready = 1'b1;
        end else if (state == ST_RESP) begin
            o_tx_valid = 1'b1;
            o_tx_data  = op_byte;
        end else if (state == ST_MREQ) begin
            if (mreq_wr) begin
                o_drx_valid = i_rx_valid;
                o_drx_data  = i_rx_data;
                o_rx_ready  = i_drx_ready;
            end else begin
                o_tx_valid  = i_dtx_valid;
                o_tx_data   = i_dtx_data;
                o_dtx_ready = i_tx_ready;
            end
        end
    end

    assign o_mreq_valid = (state == ST_MREQ);
    assign o_mreq_wr    = mreq_wr;
    assign o_mreq_wsize = mreq_wsize;
    assign o_mreq_aincr = mreq_aincr;
    assign o_mreq_size  = mreq_size;
    assign o_mreq_addr  = mreq_addr;
    assign o_busy       = (state != ST_OP);
    assign o_err_count  = err_count;

endmodule
